// File: rtl/spi_conf_rx_pkg.sv
// rtl/spi_conf_rx_pkg.sv - shared constants and FSM encoding for the SPI configuration receiver
package spi_conf_rx_pkg;

    localparam int          WORD_BITS    = 16;
    localparam int          MODE_MSB     = 15;
    localparam int          MODE_LSB     = 12;
    localparam int          CNT_W        = 5;
    localparam logic [3:0]  DEFAULT_MODE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/spi_conf_rx_sync2.sv
// rtl/spi_conf_rx_sync2.sv - two-flop synchronizer with selectable reset level
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/spi_conf_rx.sv
// rtl/spi_conf_rx.sv - SPI configuration word receiver driving the major-mode mux select
module spi_conf_rx #(
    parameter int         WORD_BITS    = spi_conf_rx_pkg::WORD_BITS,
    parameter logic [3:0] DEFAULT_MODE = spi_conf_rx_pkg::DEFAULT_MODE
) (
    input  logic        pck0,
    input  logic        nreset,
    input  logic        spck,
    input  logic        mosi,
    input  logic        ncs,
    output logic [3:0]  major_mode,
    output logic [11:0] conf_word,
    output logic        conf_strobe,
    output logic        frame_err
);

    import spi_conf_rx_pkg::*;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_BITS + 1);

    logic spck_s;
    logic mosi_s;
    logic ncs_s;

    sync2 #(.RST_VAL(1'b0)) u_sync_spck (.clk(pck0), .rst_n(nreset), .d(spck), .q(spck_s));
    sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(pck0), .rst_n(nreset), .d(mosi), .q(mosi_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_ncs  (.clk(pck0), .rst_n(nreset), .d(ncs),  .q(ncs_s));

    state_e                 state_q, state_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             major_mode_q, major_mode_d;
    logic [11:0]            conf_word_q, conf_word_d;
    logic                   conf_strobe_q, conf_strobe_d;
    logic                   frame_err_q, frame_err_d;
    logic                   spck_prev_q, spck_prev_d;
    logic                   ncs_prev_q, ncs_prev_d;
    logic [1:0]             settle_q, settle_d;
    logic                   armed_q, armed_d;

    logic sync_valid;
    logic spck_rise;
    logic ncs_rise;
    logic ncs_fall;

    // The synchronizers come out of reset at their idle levels, so ncs only counts
    // as "seen high" once the pipeline has flushed real pin values (settle_q == 2).
    always_comb begin
        sync_valid = (settle_q == 2'd2);
        spck_rise  = spck_s & ~spck_prev_q;
        ncs_rise   = ncs_s & ~ncs_prev_q;
        ncs_fall   = armed_q & ncs_prev_q & ~ncs_s;
    end

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        major_mode_d  = major_mode_q;
        conf_word_d   = conf_word_q;
        conf_strobe_d = 1'b0;
        frame_err_d   = 1'b0;
        spck_prev_d   = spck_s;
        ncs_prev_d    = ncs_s;
        settle_d      = sync_valid ? settle_q : settle_q + 2'd1;
        armed_d       = armed_q | (sync_valid & ncs_s);

        case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // ncs_s is already high on the cycle of its rising edge, which masks a coincident spck edge.
                if (ncs_rise) begin
                    if (cnt_q == CNT_FULL) begin
                        state_d = ST_COMMIT;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else if (spck_rise && !ncs_s) begin
                    shift_d = {shift_q[WORD_BITS-2:0], mosi_s};
                    cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                major_mode_d  = shift_q[MODE_MSB:MODE_LSB];
                conf_word_d   = shift_q[MODE_LSB-1:0];
                conf_strobe_d = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pck0 or negedge nreset) begin
        if (!nreset) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            cnt_q         <= '0;
            major_mode_q  <= DEFAULT_MODE;
            conf_word_q   <= '0;
            conf_strobe_q <= 1'b0;
            frame_err_q   <= 1'b0;
            spck_prev_q   <= 1'b0;
            ncs_prev_q    <= 1'b1;
            settle_q      <= 2'd0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            major_mode_q  <= major_mode_d;
            conf_word_q   <= conf_word_d;
            conf_strobe_q <= conf_strobe_d;
            frame_err_q   <= frame_err_d;
            spck_prev_q   <= spck_prev_d;
            ncs_prev_q    <= ncs_prev_d;
            settle_q      <= settle_d;
            armed_q       <= armed_d;
        end
    end

    assign major_mode  = major_mode_q;
    assign conf_word   = conf_word_q;
    assign conf_strobe = conf_strobe_q;
    assign frame_err   = frame_err_q;

endmodule
